// File: rtl/multitimer_pkg.sv
// Shared register offsets, bit indices and helpers for the multitimer block.
// Optional capture support is built when TIMER_CAPTURE_EN is defined.
package multitimer_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_CNT0   = 4'd4;
  localparam logic [3:0] OFF_CAPT0  = 4'd8;
  localparam int         CH_STRIDE  = 32'sd16;

  localparam int CTRL_RUN  = 32'sd0;
  localparam int CTRL_PER  = 32'sd1;
  localparam int CTRL_IEN  = 32'sd2;
  localparam int CTRL_CIEN = 32'sd3;

  localparam int STAT_IRQF = 32'sd0;
  localparam int STAT_OVR  = 32'sd1;
  localparam int STAT_CAPF = 32'sd2;

  // Byte idx of a value zero-extended to 32 bits; bytes beyond WIDTH come back 0.
  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] idx);
    return v[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/multitimer_if.sv
// 8-bit SuperIO CPU bus as seen by the multitimer block.
interface multitimer_if #(
  parameter int AW = 7
) ();
  logic [AW-1:0] AD;
  logic [7:0]    DI;
  logic [7:0]    DO;
  logic          rw;
  logic          cs;
  logic          irq;

  modport master (output AD, output DI, output rw, output cs, input DO, input irq);
  modport slave  (input AD, input DI, input rw, input cs, output DO, output irq);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: CTRL, STATUS, RELOAD, COUNT, SHADOW and, with
// TIMER_CAPTURE_EN, the capture synchroniser and CAPT register.
module timer_channel
  import multitimer_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [3:0] off,
  input  logic [7:0] wdata,
`ifdef TIMER_CAPTURE_EN
  input  logic       cap_in,
`endif
  output logic [7:0] rdata,
  output logic       irq_req,
  output logic       running
);

  localparam int               NB     = WIDTH / 8;
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             run_r, per_r, ien_r, irqf_r, ovr_r;
  logic [WIDTH-1:0] reload_r, count_r, shadow_r;
  logic             wr_ctrl_s, wr_stat_s, wr_cnt_s, start_s, expire_s;
  logic             cien_q_s, capf_q_s;
  logic [WIDTH-1:0] capt_q_s;
  logic [7:0]       rdata_s;

  assign wr_ctrl_s = wr_en & (off == OFF_CTRL);
  assign wr_stat_s = wr_en & (off == OFF_STATUS);
  assign wr_cnt_s  = wr_en & (off[3:2] == OFF_CNT0[3:2]);
  assign start_s   = wr_ctrl_s & wdata[CTRL_RUN] & ~run_r;
  assign expire_s  = tick & run_r & (count_r == ZERO_C);

  // Control, status, reload, live count and shadow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r    <= 1'b0;
      per_r    <= 1'b0;
      ien_r    <= 1'b0;
      irqf_r   <= 1'b0;
      ovr_r    <= 1'b0;
      reload_r <= ZERO_C;
      count_r  <= ZERO_C;
      shadow_r <= ZERO_C;
    end else begin
      if (wr_ctrl_s) begin
        run_r <= wdata[CTRL_RUN];
        per_r <= wdata[CTRL_PER];
        ien_r <= wdata[CTRL_IEN];
      end else if (expire_s && !per_r) begin
        run_r <= 1'b0;
      end
      // A fresh start takes priority over a coincident tick
      if (start_s) begin
        count_r <= reload_r;
      end else if (tick && run_r) begin
        if (count_r == ZERO_C) begin
          count_r <= per_r ? reload_r : ZERO_C;
        end else begin
          count_r <= count_r - ONE_C;
        end
      end
      if (expire_s) begin
        irqf_r <= 1'b1;
      end else if (wr_stat_s && wdata[STAT_IRQF]) begin
        irqf_r <= 1'b0;
      end
      if (expire_s && irqf_r) begin
        ovr_r <= 1'b1;
      end else if (wr_stat_s && wdata[STAT_OVR]) begin
        ovr_r <= 1'b0;
      end
      for (int k = 0; k < NB; k++) begin
        if (wr_cnt_s && (off[1:0] == 2'(k))) begin
          reload_r[8*k +: 8] <= wdata;
        end
      end
      if (rd_en && (off == OFF_CNT0)) begin
        shadow_r <= count_r;
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       sync_r;
  logic             cien_r, capf_r, cap_edge_s;
  logic [WIDTH-1:0] capt_r;

  assign cap_edge_s = sync_r[1] & ~sync_r[2];

  // Capture input synchroniser, edge capture and CAPF/CIEN state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 3'b000;
      cien_r <= 1'b0;
      capf_r <= 1'b0;
      capt_r <= ZERO_C;
    end else begin
      sync_r <= {sync_r[1:0], cap_in};
      if (wr_ctrl_s) begin
        cien_r <= wdata[CTRL_CIEN];
      end
      if (cap_edge_s) begin
        capt_r <= count_r;
        capf_r <= 1'b1;
      end else if (wr_stat_s && wdata[STAT_CAPF]) begin
        capf_r <= 1'b0;
      end
    end
  end

  assign cien_q_s = cien_r;
  assign capf_q_s = capf_r;
  assign capt_q_s = capt_r;
`else
  assign cien_q_s = 1'b0;
  assign capf_q_s = 1'b0;
  assign capt_q_s = ZERO_C;
`endif

  // Per-channel read mux; +4 is the live LSB, +5..+7 come from the shadow
  always_comb begin
    rdata_s = 8'd0;
    case (off)
      OFF_CTRL: begin
        rdata_s[CTRL_RUN]  = run_r;
        rdata_s[CTRL_PER]  = per_r;
        rdata_s[CTRL_IEN]  = ien_r;
        rdata_s[CTRL_CIEN] = cien_q_s;
      end
      OFF_STATUS: begin
        rdata_s[STAT_IRQF] = irqf_r;
        rdata_s[STAT_OVR]  = ovr_r;
        rdata_s[STAT_CAPF] = capf_q_s;
      end
      OFF_CNT0, 4'd5, 4'd6, 4'd7:
        rdata_s = byte_of((off == OFF_CNT0) ? 32'(count_r) : 32'(shadow_r), off[1:0]);
      OFF_CAPT0, 4'd9, 4'd10, 4'd11:
        rdata_s = byte_of(32'(capt_q_s), off[1:0]);
      default: rdata_s = 8'd0;
    endcase
  end

  assign rdata   = rd_en ? rdata_s : 8'd0;
  assign irq_req = (irqf_r & ien_r) | (capf_q_s & cien_q_s);
  assign running = run_r;

endmodule

// File: rtl/multitimer.sv
// N-channel programmable interval timer on the SuperIO bus: shared prescaler,
// address decode, read mux and irq combine. Capture inputs with TIMER_CAPTURE_EN.
module multitimer
  import multitimer_pkg::*;
#(
  parameter int CH    = 4,
  parameter int WIDTH = 24,
  parameter int AW    = 7
) (
  input logic           clk,
  input logic           rst,
  multitimer_if.slave   bus
`ifdef TIMER_CAPTURE_EN
  ,
  input logic [CH-1:0]  cap
`endif
);

  logic          wr_s, rd_s, any_run_s, tick_s, presc_lo_s, presc_hi_s;
  logic [15:0]   presc_r, pcnt_r;
  logic [CH-1:0] run_vec_s, irq_vec_s, sel_s;
  logic [7:0]    ch_rdata_s [CH];
  logic [7:0]    do_s;
  logic [AW-5:0] blk_s;

  assign wr_s       = bus.cs & ~bus.rw;
  assign rd_s       = bus.cs & bus.rw;
  assign blk_s      = bus.AD[AW-1:4];
  assign presc_lo_s = (bus.AD == AW'(CH * CH_STRIDE));
  assign presc_hi_s = (bus.AD == AW'(CH * CH_STRIDE + 32'sd1));
  assign any_run_s  = |run_vec_s;
  assign tick_s     = any_run_s & (pcnt_r == 16'd0);

  // Shared prescaler: parked at PRESC while idle, reloads after each tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= 16'd0;
      pcnt_r  <= 16'd0;
    end else begin
      if (wr_s && presc_lo_s) begin
        presc_r[7:0] <= bus.DI;
      end
      if (wr_s && presc_hi_s) begin
        presc_r[15:8] <= bus.DI;
      end
      if (!any_run_s || (pcnt_r == 16'd0)) begin
        pcnt_r <= presc_r;
      end else begin
        pcnt_r <= pcnt_r - 16'd1;
      end
    end
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    assign sel_s[n] = (blk_s == (AW-4)'(n));
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_s),
      .wr_en   (wr_s & sel_s[n]),
      .rd_en   (rd_s & sel_s[n]),
      .off     (bus.AD[3:0]),
      .wdata   (bus.DI),
`ifdef TIMER_CAPTURE_EN
      .cap_in  (cap[n]),
`endif
      .rdata   (ch_rdata_s[n]),
      .irq_req (irq_vec_s[n]),
      .running (run_vec_s[n])
    );
  end

  // Read data: channel outputs are already zero unless selected, so OR them in
  always_comb begin
    do_s = 8'd0;
    if (rd_s && presc_lo_s) begin
      do_s = presc_r[7:0];
    end else if (rd_s && presc_hi_s) begin
      do_s = presc_r[15:8];
    end else begin
      do_s = 8'd0;
    end
    for (int n = 0; n < CH; n++) begin
      do_s = do_s | ch_rdata_s[n];
    end
  end

  assign bus.DO  = do_s;
  assign bus.irq = |irq_vec_s;

endmodule
